i2s_tx_multi: RTL and testbench

- Parametrised successor to the fixed stereo 24-bit I2S transmitter that feeds the board codec from the OPL3 sample stream.
- Generalised in sample width, slot width, channel count (stereo I2S or TDM), SCLK divide ratio and framing mode (I2S vs left-justified).
- Adds a frame FIFO with valid/ready backpressure and underrun reporting.
- Sits between the synth/mixer sample output and the codec pins, entirely in the 12 MHz audio clock domain.

---
 rtl/i2s_tx_multi_if.sv | 18 +
 rtl/i2s_tx_multi.sv | 149 ++++++++++++++
 tb/tb_i2s_tx_multi.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_multi_if
// Purpose  : Frame input handshake (samples / valid / ready) for i2s_tx_multi.
// Revision : 1.0
// ============================================================================
interface i2s_tx_multi_if #(
   parameter int NUM_CHANNELS = 2,
   parameter int SAMPLE_WIDTH = 24
);
   logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] samples;
   logic                                 sample_valid;
   logic                                 sample_ready;

   modport master (output samples, output sample_valid, input sample_ready);
   modport slave  (input samples, input sample_valid, output sample_ready);
endinterface
`default_nettype wire

// File: rtl/i2s_tx_multi.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_multi
// Purpose  : Parametrised I2S / left-justified / TDM transmitter with a frame
//            FIFO, valid/ready input and underrun reporting.
// Revision : 1.0
// ============================================================================
module i2s_tx_multi #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int SLOT_WIDTH   = 32,
   parameter int NUM_CHANNELS = 2,
   parameter int SCLK_DIV     = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   i2s_tx_multi_if.slave               s_if,
   input  logic                        mode_i2s,
   output logic                        i2s_sclk,
   output logic                        i2s_ws,
   output logic                        i2s_sd,
   output logic                        underrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int c_FRAME_W = NUM_CHANNELS * SAMPLE_WIDTH;
   localparam int c_BITS    = NUM_CHANNELS * SLOT_WIDTH;
   localparam int c_BP_W    = $clog2(c_BITS);
   localparam int c_HALF    = SCLK_DIV / 2;
   localparam int c_DIV_W   = (c_HALF > 1) ? $clog2(c_HALF) : 1;
   localparam int c_AW      = $clog2(FIFO_DEPTH);
   localparam int c_LVL_W   = c_AW + 1;

   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_HALF - 1);
   localparam logic [c_BP_W-1:0]  c_BP_LAST  = c_BP_W'(c_BITS - 1);
   localparam logic [c_BP_W-1:0]  c_SLOT1    = c_BP_W'(SLOT_WIDTH);
   localparam logic [c_LVL_W-1:0] c_FULL     = c_LVL_W'(FIFO_DEPTH);

   logic [c_DIV_W-1:0]   div_q, div_d;
   logic                 sclk_q, sclk_d;
   logic [c_BP_W-1:0]    bitpos_q, bitpos_d;
   logic [c_FRAME_W-1:0] frame_q, frame_d;
   logic                 mode_q, mode_d;
   logic                 ws_q, ws_d;
   logic                 sd_q, sd_d;
   logic                 underrun_q, underrun_d;
   logic [c_FRAME_W-1:0] mem_q [FIFO_DEPTH];
   logic [c_AW-1:0]      wr_q, rd_q;
   logic [c_LVL_W-1:0]   level_q, level_d;

   logic                 w_tick, w_fall, w_wrap, w_empty, w_push, w_pop;
   logic [c_BITS-1:0]    w_ser_cur, w_ser_nxt;

   assign s_if.sample_ready = (level_q != c_FULL);

   always_comb begin
      w_tick     = (div_q == c_DIV_LAST);
      w_fall     = w_tick & sclk_q;
      w_wrap     = w_fall & (bitpos_q == c_BP_LAST);
      w_empty    = (level_q == '0);
      w_push     = s_if.sample_valid & s_if.sample_ready;
      w_pop      = w_wrap & ~w_empty;
      div_d      = w_tick ? '0 : div_q + 1'b1;
      sclk_d     = w_tick ? ~sclk_q : sclk_q;
      bitpos_d   = bitpos_q;
      frame_d    = frame_q;
      mode_d     = mode_q;
      underrun_d = w_wrap & w_empty;
      if (w_fall) begin
         bitpos_d = w_wrap ? '0 : bitpos_q + 1'b1;
      end
      // FIFO head is read straight through so the new frame starts on this fall
      if (w_wrap) begin
         frame_d = w_empty ? '0 : mem_q[rd_q];
         mode_d  = mode_i2s;
      end
      level_d = level_q;
      if (w_push && !w_pop) begin
         level_d = level_q + 1'b1;
      end else if (!w_push && w_pop) begin
         level_d = level_q - 1'b1;
      end
   end

   // Serial bit p of a frame: slot p/SLOT_WIDTH, sample MSB first, zero padded
   for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
      for (genvar b = 0; b < SLOT_WIDTH; b++) begin : g_bit
         if (b < SAMPLE_WIDTH) begin : g_data
            assign w_ser_cur[ch*SLOT_WIDTH + b] = frame_q[ch*SAMPLE_WIDTH + SAMPLE_WIDTH - 1 - b];
            assign w_ser_nxt[ch*SLOT_WIDTH + b] = frame_d[ch*SAMPLE_WIDTH + SAMPLE_WIDTH - 1 - b];
         end else begin : g_pad
            assign w_ser_cur[ch*SLOT_WIDTH + b] = 1'b0;
            assign w_ser_nxt[ch*SLOT_WIDTH + b] = 1'b0;
         end
      end
   end

   // I2S repeats the bit that was just sent at the old position: one SCLK late
   always_comb begin
      ws_d = ws_q;
      sd_d = sd_q;
      if (w_fall) begin
         ws_d = (NUM_CHANNELS == 2) ? (bitpos_d >= c_SLOT1) : (bitpos_d == '0);
         sd_d = mode_d ? w_ser_cur[bitpos_q] : w_ser_nxt[bitpos_d];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q      <= '0;
         sclk_q     <= 1'b0;
         bitpos_q   <= '0;
         frame_q    <= '0;
         mode_q     <= 1'b0;
         ws_q       <= 1'b0;
         sd_q       <= 1'b0;
         underrun_q <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         level_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         div_q      <= div_d;
         sclk_q     <= sclk_d;
         bitpos_q   <= bitpos_d;
         frame_q    <= frame_d;
         mode_q     <= mode_d;
         ws_q       <= ws_d;
         sd_q       <= sd_d;
         underrun_q <= underrun_d;
         level_q    <= level_d;
         if (w_push) begin
            mem_q[wr_q] <= s_if.samples;
            wr_q        <= wr_q + 1'b1;
         end
         if (w_pop) begin
            rd_q <= rd_q + 1'b1;
         end
      end
   end

   assign i2s_sclk   = sclk_q;
   assign i2s_ws     = ws_q;
   assign i2s_sd     = sd_q;
   assign underrun   = underrun_q;
   assign fifo_level = level_q;
endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx_multi
// Purpose  : Scoreboard bench: stereo 24/32 instance and 8-channel TDM 16/16.
// Revision : 1.0
// ============================================================================
module tb_i2s_tx_multi;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic mode_st = 1'b0;
   logic mode_td = 1'b0;
   logic st_sclk, st_ws, st_sd, st_und;
   logic td_sclk, td_ws, td_sd, td_und;
   logic [2:0] st_lvl, td_lvl;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit st_i2s_mon = 1'b0;

   logic [63:0]  st_exp[$];
   logic [127:0] td_exp[$];

   i2s_tx_multi_if #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(24)) st_if();
   i2s_tx_multi_if #(.NUM_CHANNELS(8), .SAMPLE_WIDTH(16)) td_if();

   i2s_tx_multi #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .NUM_CHANNELS(2),
                  .SCLK_DIV(4), .FIFO_DEPTH(4)) u_st (
      .clk(clk), .reset(reset), .s_if(st_if), .mode_i2s(mode_st),
      .i2s_sclk(st_sclk), .i2s_ws(st_ws), .i2s_sd(st_sd),
      .underrun(st_und), .fifo_level(st_lvl));

   i2s_tx_multi #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .NUM_CHANNELS(8),
                  .SCLK_DIV(4), .FIFO_DEPTH(4)) u_td (
      .clk(clk), .reset(reset), .s_if(td_if), .mode_i2s(mode_td),
      .i2s_sclk(td_sclk), .i2s_ws(td_ws), .i2s_sd(td_sd),
      .underrun(td_und), .fifo_level(td_lvl));

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic st_frame(input logic [63:0] f);
      if (f != '0) begin
         if (st_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL st_unexpected_frame: got %h expected none", f);
         end else begin
            check("st_frame", f, st_exp.pop_front());
         end
      end
   endtask

   task automatic td_frame(input logic [127:0] f);
      if (f != '0) begin
         if (td_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL td_unexpected_frame: got %h expected none", f);
         end else begin
            check("td_slot3", f[79:64], 16'h3333);
            check("td_frame", f, td_exp.pop_front());
         end
      end
   endtask

   // Stereo monitor: captures sd on SCLK rise, frames delimited by ws falling
   initial begin : mon_st
      logic [63:0] sh;
      logic pws, psc;
      int cnt;
      bit seen;
      sh = '0; pws = 0; psc = 0; cnt = 0; seen = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            sh = '0; pws = 0; psc = 0; cnt = 0; seen = 0;
         end else begin
            if (st_sclk && !psc) begin
               if (st_ws != pws && seen) check("st_ws_slot_len", cnt, 32);
               if (st_ws != pws) cnt = 0;
               if (!st_i2s_mon && pws && !st_ws && seen) st_frame(sh);
               sh = {sh[62:0], st_sd};
               if (st_i2s_mon && pws && !st_ws && seen) st_frame(sh);
               if (st_ws != pws) seen = 1;
               pws = st_ws;
               cnt++;
            end
            psc = st_sclk;
         end
      end
   end

   // TDM monitor: ws pulse marks bitpos 0 of each 128-bit frame
   initial begin : mon_td
      logic [127:0] sh;
      logic psc;
      int cnt;
      bit seen;
      sh = '0; psc = 0; cnt = 0; seen = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            sh = '0; psc = 0; cnt = 0; seen = 0;
         end else begin
            if (td_sclk && !psc) begin
               if (td_ws) begin
                  if (seen) begin
                     check("td_frame_len", cnt, 128);
                     td_frame(sh);
                  end
                  seen = 1;
                  cnt = 0;
               end
               sh = {sh[126:0], td_sd};
               cnt++;
            end
            psc = td_sclk;
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic do_reset(input bit mi2s);
      @(negedge clk);
      #2 reset = 1'b1;
      mode_st = mi2s;
      st_i2s_mon = mi2s;
      st_if.sample_valid = 1'b0;
      td_if.sample_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic push_st(input logic [23:0] l, input logic [23:0] r);
      st_if.samples = {r, l};
      st_if.sample_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (st_if.sample_ready) begin
            st_exp.push_back({l, 8'h00, r, 8'h00});
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      checks++; failures++;
      $display("FAIL st_push_timeout: got ready=0 expected ready=1");
   endtask

   task automatic push_td();
      td_if.samples = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
      td_if.sample_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (td_if.sample_ready) begin
            td_exp.push_back(128'h0000_1111_2222_3333_4444_5555_6666_7777);
            @(negedge clk);
            td_if.sample_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      td_if.sample_valid = 1'b0;
      checks++; failures++;
      $display("FAIL td_push_timeout: got ready=0 expected ready=1");
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_sclk"}, st_sclk, 0);
      check({tag, "_ws"}, st_ws, 0);
      check({tag, "_sd"}, st_sd, 0);
      check({tag, "_und"}, st_und, 0);
      check({tag, "_lvl"}, st_lvl, 0);
      check({tag, "_ready"}, st_if.sample_ready, 1);
   endtask

   logic [23:0] fl [5] = '{24'h000001, 24'h7FFFFF, 24'h800000, 24'hFFFFFF, 24'h123456};
   logic [23:0] fr [5] = '{24'hFEDCBA, 24'h000002, 24'h555555, 24'hAAAAAA, 24'h0F0F0F};

   initial begin : stim
      int und_cnt, und1, und2, rise1, rise2;
      bit sd_seen;
      logic psc;
      st_if.samples = '0; st_if.sample_valid = 1'b0;
      td_if.samples = '0; td_if.sample_valid = 1'b0;

      // Phase A: reset values and idle stream
      #1 reset = 1'b1;
      #1;
      check_reset_vals("rst");
      check("td_rst_ws", td_ws, 0);
      check("td_rst_lvl", td_lvl, 0);
      check("td_rst_ready", td_if.sample_ready, 1);
      @(negedge clk);
      #2 reset = 1'b0;
      und_cnt = 0; und1 = -1; und2 = -1; rise1 = -1; rise2 = -1; sd_seen = 0; psc = 0;
      while (cyc < 600) begin
         @(negedge clk);
         if (st_und) begin
            und_cnt++;
            if (und1 < 0) und1 = cyc; else if (und2 < 0) und2 = cyc;
         end
         if (st_sd) sd_seen = 1;
         if (st_sclk && !psc) begin
            if (rise1 < 0) rise1 = cyc; else if (rise2 < 0) rise2 = cyc;
         end
         psc = st_sclk;
      end
      check("first_sclk_rise", rise1, 2);
      check("second_sclk_rise", rise2, 6);
      check("idle_underrun_count", und_cnt, 2);
      check("idle_underrun_first", und1, 256);
      check("idle_underrun_second", und2, 512);
      check("idle_sd_zero", sd_seen, 0);

      // Phase B: left-justified data, stereo and TDM
      do_reset(1'b0);
      push_td();
      push_st(24'hA5A5A5, 24'h800001);
      st_if.sample_valid = 1'b0;
      wait_cyc(256);
      check("lj_no_underrun", st_und, 0);
      check("lj_bit0_msb", st_sd, 1);
      check("lj_ws_left", st_ws, 0);
      check("lj_level_popped", st_lvl, 0);
      wait_cyc(1100);

      // Phase C: I2S mode, same data
      do_reset(1'b1);
      push_st(24'hA5A5A5, 24'h800001);
      st_if.sample_valid = 1'b0;
      wait_cyc(256);
      check("i2s_bit0_prev_last", st_sd, 0);
      check("i2s_ws_left", st_ws, 0);
      wait_cyc(260);
      check("i2s_first_msb", st_sd, 1);
      wait_cyc(600);

      // Phase D: FIFO fill with valid held
      do_reset(1'b0);
      for (int k = 0; k < 4; k++) begin
         push_st(fl[k], fr[k]);
         check("fill_level", st_lvl, k + 1);
      end
      check("full_ready_low", st_if.sample_ready, 0);
      st_if.samples = {fr[4], fl[4]};
      wait_cyc(200);
      check("full_ignore_valid", st_lvl, 4);
      wait_cyc(255);
      check("full_before_pop", st_lvl, 4);
      wait_cyc(256);
      check("pop_level", st_lvl, 3);
      check("pop_ready", st_if.sample_ready, 1);
      st_exp.push_back({fl[4], 8'h00, fr[4], 8'h00});
      wait_cyc(257);
      check("refill_level", st_lvl, 4);
      check("refill_ready", st_if.sample_ready, 0);
      st_if.sample_valid = 1'b0;
      wait_cyc(1600);

      // Phase E: asynchronous reset mid-frame with frames queued
      do_reset(1'b0);
      for (int k = 0; k < 3; k++) push_st(fl[k], fr[k]);
      st_if.sample_valid = 1'b0;
      wait_cyc(162);
      check("pre_reset_ws", st_ws, 1);
      check("pre_reset_lvl", st_lvl, 3);
      #1 reset = 1'b1;
      #1;
      check_reset_vals("async_rst");
      st_exp.delete();
      @(negedge clk);
      #2 reset = 1'b0;
      wait_cyc(256);
      check("post_reset_underrun", st_und, 1);
      wait_cyc(600);

      check("st_queue_empty", st_exp.size(), 0);
      check("td_queue_empty", td_exp.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
